// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
//   Multi-digit BCD event counter with a time-multiplexed scan driver for
//   the HC_4511 BCD-to-7-segment decoder. After reset it runs a lamp test.
//   It then scans the digits in turn onto one shared 4511 input bus. Between
//   two digits it inserts a single blanked cycle so that the old digit does
//   not ghost onto the next common.
//
// Parameters
//   DIGITS            number of BCD digits counted and scanned (1..8)
//   SCAN_DIV          clock cycles each digit is shown (>=2)
//   LAMP_TEST_CYCLES  cycles lt_n is held low after reset (>=1)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   en         count enable
//   inc        increment request, sampled each cycle
//   clr        synchronous counter clear (priority over inc)
//   hold       freeze displayed value; the counter keeps running
//   count_bcd  live counter, digit 0 in bits [3:0]
//   carry_out  one-cycle pulse on full-scale wrap
//   bcd_a      BCD digit to decoder A[3:0]
//   le         decoder latch enable, fixed 0 (transparent)
//   bi_n       decoder blanking, active-low
//   lt_n       decoder lamp test, active-low
//   digit_sel  digit common select, active-low one-hot
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                          during their SHOW interval (digit 0 never is)

module bcd_scan_driver #(
    parameter int unsigned DIGITS           = 4,
    parameter int unsigned SCAN_DIV         = 1000,
    parameter int unsigned LAMP_TEST_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  inc,
    input  logic                  clr,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  carry_out,
    output logic [3:0]            bcd_a,
    output logic                  le,
    output logic                  bi_n,
    output logic                  lt_n,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned TMAX = (SCAN_DIV > LAMP_TEST_CYCLES) ? SCAN_DIV : LAMP_TEST_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        LAMP,
        BLANK,
        SHOW
    } state_t;

    state_t               state, state_next;
    logic [TW-1:0]        timer, timer_next;
    logic [IW-1:0]        idx, idx_next;
    logic [4*DIGITS-1:0]  disp;
    logic                 hold_q;

    logic [4*DIGITS-1:0]  count_next;
    logic                 carry_next;
    logic                 c;

    logic [3:0]           a_next;
    logic                 bi_next;
    logic                 lt_next;
    logic [DIGITS-1:0]    sel_next;

`ifdef LEADING_ZERO_BLANK_EN
    logic                 lzb, lzb_next;
`endif

    // Select one BCD digit out of the packed display vector.
    function automatic logic [3:0] digit_of(input logic [4*DIGITS-1:0] v,
                                            input logic [IW-1:0] i);
        logic [3:0] r;
        r = 4'd0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (IW'(d) == i) r = v[4*d +: 4];
        end
        return r;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // True when digit i and every higher digit are zero; digit 0 never qualifies.
    function automatic logic lead_zero(input logic [4*DIGITS-1:0] v,
                                       input logic [IW-1:0] i);
        logic z;
        z = (i != '0);
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if ((IW'(d) >= i) && (v[4*d +: 4] != 4'd0)) z = 1'b0;
        end
        return z;
    endfunction
`endif

    // ---------------------------------------------------------------
    // BCD counter next value
    // ---------------------------------------------------------------
    always_comb begin
        count_next = count_bcd;
        carry_next = 1'b0;
        c          = 1'b1;
        if (clr) begin
            count_next = '0;
        end else if (en && inc) begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (c) begin
                    if (count_bcd[4*d +: 4] == 4'd9) begin
                        count_next[4*d +: 4] = 4'd0;
                    end else begin
                        count_next[4*d +: 4] = count_bcd[4*d +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
            // Carry still set means every digit rolled over from 9.
            carry_next = c;
        end
    end

    // ---------------------------------------------------------------
    // Scan FSM next state and next (registered) decoder outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        timer_next = timer + TW'(1);
        idx_next   = idx;
        a_next     = bcd_a;
        bi_next    = bi_n;
        lt_next    = lt_n;
        sel_next   = digit_sel;
`ifdef LEADING_ZERO_BLANK_EN
        lzb_next   = lzb;
`endif
        case (state)
            LAMP: begin
                if (timer == TW'(LAMP_TEST_CYCLES - 1)) begin
                    state_next = BLANK;
                    timer_next = '0;
                    idx_next   = '0;
                end
            end
            BLANK: begin
                state_next = SHOW;
                timer_next = '0;
                lt_next    = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                bi_next    = ~lzb;
`else
                bi_next    = 1'b1;
`endif
                for (int unsigned d = 0; d < DIGITS; d++) begin
                    sel_next[d] = (IW'(d) != idx);
                end
            end
            SHOW: begin
                if (timer == TW'(SCAN_DIV - 1)) begin
                    state_next = BLANK;
                    timer_next = '0;
                    idx_next   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
                end
            end
            default: begin
                state_next = LAMP;
                timer_next = '0;
            end
        endcase

        // Outputs are registered, so the BLANK-cycle values (including the
        // digit that SHOW will display) are loaded on the edge entering BLANK.
        if (state != BLANK && state_next == BLANK) begin
            bi_next  = 1'b0;
            lt_next  = 1'b1;
            sel_next = '1;
            a_next   = digit_of(disp, idx_next);
`ifdef LEADING_ZERO_BLANK_EN
            lzb_next = lead_zero(disp, idx_next);
`endif
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bcd <= '0;
            carry_out <= 1'b0;
            disp      <= '0;
            hold_q    <= 1'b0;
            state     <= LAMP;
            timer     <= '0;
            idx       <= '0;
            bcd_a     <= 4'd0;
            le        <= 1'b0;
            bi_n      <= 1'b1;
            lt_n      <= 1'b0;
            digit_sel <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            lzb       <= 1'b0;
`endif
        end else begin
            count_bcd <= count_next;
            carry_out <= carry_next;
            hold_q    <= hold;
            // Capture on the first cycle hold is high, then stay frozen.
            if (!hold || !hold_q) disp <= count_bcd;
            state     <= state_next;
            timer     <= timer_next;
            idx       <= idx_next;
            bcd_a     <= a_next;
            le        <= 1'b0;
            bi_n      <= bi_next;
            lt_n      <= lt_next;
            digit_sel <= sel_next;
`ifdef LEADING_ZERO_BLANK_EN
            lzb       <= lzb_next;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed testbench for bcd_scan_driver (DIGITS=4, SCAN_DIV=4,
// LAMP_TEST_CYCLES=8). Follows LEADING_ZERO_BLANK_EN for blanking expectations.

module tb_bcd_scan_driver;

    logic        clk = 1'b0;
    logic        rst, en, inc, clr, hold;
    logic [15:0] count_bcd;
    logic        carry_out;
    logic [3:0]  bcd_a;
    logic        le, bi_n, lt_n;
    logic [3:0]  digit_sel;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bcd_scan_driver #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .LAMP_TEST_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .inc(inc),
        .clr(clr),
        .hold(hold),
        .count_bcd(count_bcd),
        .carry_out(carry_out),
        .bcd_a(bcd_a),
        .le(le),
        .bi_n(bi_n),
        .lt_n(lt_n),
        .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next sampled BLANK cycle (bounded).
    task automatic wait_blank(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bi_n === 1'b0 && digit_sel === 4'b1111) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Advance to the first SHOW cycle of the digit with the given select.
    task automatic find_show(input logic [3:0] want, output bit ok);
        bit b;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            wait_blank(b);
            if (!b) break;
            @(negedge clk);
            if (digit_sel === want) ok = 1'b1;
        end
    endtask

    task automatic pulse_clr;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; inc = 1'b0; clr = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({count_bcd, carry_out, bcd_a, le, bi_n, lt_n, digit_sel} !==
            {16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL reset_state: got cnt=%h co=%b a=%h le=%b bi=%b lt=%b sel=%b expected cnt=0000 co=0 a=0 le=0 bi=1 lt=0 sel=0000",
                     count_bcd, carry_out, bcd_a, le, bi_n, lt_n, digit_sel);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({lt_n, bi_n, digit_sel} !== {1'b0, 1'b1, 4'b0000}) begin
                bad++;
                $display("FAIL lamp_test[%0d]: got lt=%b bi=%b sel=%b expected lt=0 bi=1 sel=0000", i, lt_n, bi_n, digit_sel);
            end
            @(negedge clk);
        end
        total++;
        if ({bi_n, lt_n, digit_sel} !== {1'b0, 1'b1, 4'b1111}) begin
            bad++;
            $display("FAIL first_blank: got bi=%b lt=%b sel=%b expected bi=0 lt=1 sel=1111", bi_n, lt_n, digit_sel);
        end
        @(negedge clk);
        total++;
        if ({bi_n, lt_n, digit_sel, bcd_a} !== {1'b1, 1'b1, 4'b1110, 4'h0}) begin
            bad++;
            $display("FAIL first_show: got bi=%b lt=%b sel=%b a=%h expected bi=1 lt=1 sel=1110 a=0", bi_n, lt_n, digit_sel, bcd_a);
        end
    endtask

    task automatic test_count_scan;
        logic [3:0] sels [3];
        logic [3:0] vals [3];
        bit ok;
        int t0;
        sels = '{4'b1101, 4'b1011, 4'b0111};
        vals = '{4'h1, 4'h0, 4'h0};
        en = 1'b1; inc = 1'b1;
        repeat (12) @(negedge clk);
        inc = 1'b0;
        total++;
        if ({count_bcd, carry_out} !== {16'h0012, 1'b0}) begin
            bad++;
            $display("FAIL count_12: got cnt=%h co=%b expected cnt=0012 co=0", count_bcd, carry_out);
        end
        en = 1'b0; inc = 1'b1;
        repeat (5) @(negedge clk);
        inc = 1'b0; en = 1'b1;
        total++;
        if (count_bcd !== 16'h0012) begin
            bad++;
            $display("FAIL en_gate: got cnt=%h expected 0012", count_bcd);
        end
        repeat (25) @(negedge clk);
        find_show(4'b1110, ok);
        t0 = cyc;
        total++;
        if (!ok || bcd_a !== 4'h2) begin
            bad++;
            $display("FAIL scan_d0: got found=%b a=%h expected found=1 a=2", ok, bcd_a);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({digit_sel, bcd_a} !== {4'b1110, 4'h2}) begin
            bad++;
            $display("FAIL scan_d0_stable: got sel=%b a=%h expected sel=1110 a=2", digit_sel, bcd_a);
        end
        for (int k = 0; k < 3; k++) begin
            wait_blank(ok);
            @(negedge clk);
            total++;
            if (!ok || digit_sel !== sels[k] || bcd_a !== vals[k]) begin
                bad++;
                $display("FAIL scan_d%0d: got found=%b sel=%b a=%h expected sel=%b a=%h", k + 1, ok, digit_sel, bcd_a, sels[k], vals[k]);
            end
        end
        find_show(4'b1110, ok);
        total++;
        if (!ok || (cyc - t0) != 20) begin
            bad++;
            $display("FAIL scan_period: got %0d cycles (found=%b) expected 20", cyc - t0, ok);
        end
    endtask

    task automatic test_wrap;
        pulse_clr();
        total++;
        if (count_bcd !== 16'h0000) begin
            bad++;
            $display("FAIL clr: got cnt=%h expected 0000", count_bcd);
        end
        en = 1'b1; inc = 1'b1;
        repeat (9999) @(negedge clk);
        inc = 1'b0;
        total++;
        if ({count_bcd, carry_out} !== {16'h9999, 1'b0}) begin
            bad++;
            $display("FAIL full_scale: got cnt=%h co=%b expected cnt=9999 co=0", count_bcd, carry_out);
        end
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        total++;
        if ({count_bcd, carry_out} !== {16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL wrap: got cnt=%h co=%b expected cnt=0000 co=1", count_bcd, carry_out);
        end
        @(negedge clk);
        total++;
        if ({count_bcd, carry_out} !== {16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL carry_width: got cnt=%h co=%b expected cnt=0000 co=0", count_bcd, carry_out);
        end
        inc = 1'b1;
        repeat (9999) @(negedge clk);
        inc = 1'b1; clr = 1'b1;
        @(negedge clk);
        inc = 1'b0; clr = 1'b0;
        total++;
        if ({count_bcd, carry_out} !== {16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL clr_over_inc: got cnt=%h co=%b expected cnt=0000 co=0", count_bcd, carry_out);
        end
    endtask

    task automatic test_hold;
        bit ok;
        pulse_clr();
        inc = 1'b1;
        repeat (5) @(negedge clk);
        inc = 1'b0;
        repeat (3) @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        inc = 1'b1;
        repeat (3) @(negedge clk);
        inc = 1'b0;
        total++;
        if (count_bcd !== 16'h0008) begin
            bad++;
            $display("FAIL hold_count: got cnt=%h expected 0008", count_bcd);
        end
        repeat (25) @(negedge clk);
        find_show(4'b1110, ok);
        total++;
        if (!ok || bcd_a !== 4'h5) begin
            bad++;
            $display("FAIL hold_frozen: got found=%b a=%h expected a=5", ok, bcd_a);
        end
        hold = 1'b0;
        find_show(4'b1110, ok);
        total++;
        if (!ok || bcd_a !== 4'h8) begin
            bad++;
            $display("FAIL hold_release: got found=%b a=%h expected a=8", ok, bcd_a);
        end
    endtask

    task automatic test_reset_mid_scan;
        bit ok;
        find_show(4'b1011, ok);
        total++;
        if (!ok || bcd_a !== 4'h0) begin
            bad++;
            $display("FAIL pre_rst_d2: got found=%b a=%h expected found=1 a=0", ok, bcd_a);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({count_bcd, carry_out, bcd_a, bi_n, lt_n, digit_sel} !==
            {16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL async_rst: got cnt=%h co=%b a=%h bi=%b lt=%b sel=%b expected cnt=0000 co=0 a=0 bi=1 lt=0 sel=0000",
                     count_bcd, carry_out, bcd_a, bi_n, lt_n, digit_sel);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({lt_n, bi_n, digit_sel} !== {1'b0, 1'b1, 4'b0000}) begin
                bad++;
                $display("FAIL relamp[%0d]: got lt=%b bi=%b sel=%b expected lt=0 bi=1 sel=0000", i, lt_n, bi_n, digit_sel);
            end
            @(negedge clk);
        end
        total++;
        if ({bi_n, lt_n, digit_sel} !== {1'b0, 1'b1, 4'b1111}) begin
            bad++;
            $display("FAIL relamp_blank: got bi=%b lt=%b sel=%b expected bi=0 lt=1 sel=1111", bi_n, lt_n, digit_sel);
        end
    endtask

    task automatic test_leading_zero;
        bit ok;
        logic exp_bi;
`ifdef LEADING_ZERO_BLANK_EN
        exp_bi = 1'b0;
`else
        exp_bi = 1'b1;
`endif
        pulse_clr();
        en = 1'b1; inc = 1'b1;
        repeat (42) @(negedge clk);
        inc = 1'b0;
        total++;
        if (count_bcd !== 16'h0042) begin
            bad++;
            $display("FAIL count_42: got cnt=%h expected 0042", count_bcd);
        end
        repeat (25) @(negedge clk);
        find_show(4'b1110, ok);
        total++;
        if (!ok || {bi_n, bcd_a} !== {1'b1, 4'h2}) begin
            bad++;
            $display("FAIL lz_d0: got found=%b bi=%b a=%h expected bi=1 a=2", ok, bi_n, bcd_a);
        end
        wait_blank(ok);
        @(negedge clk);
        total++;
        if (!ok || {digit_sel, bi_n, bcd_a} !== {4'b1101, 1'b1, 4'h4}) begin
            bad++;
            $display("FAIL lz_d1: got sel=%b bi=%b a=%h expected sel=1101 bi=1 a=4", digit_sel, bi_n, bcd_a);
        end
        wait_blank(ok);
        @(negedge clk);
        total++;
        if (!ok || {digit_sel, bi_n, bcd_a} !== {4'b1011, exp_bi, 4'h0}) begin
            bad++;
            $display("FAIL lz_d2: got sel=%b bi=%b a=%h expected sel=1011 bi=%b a=0", digit_sel, bi_n, bcd_a, exp_bi);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({digit_sel, bi_n} !== {4'b1011, exp_bi}) begin
            bad++;
            $display("FAIL lz_d2_end: got sel=%b bi=%b expected sel=1011 bi=%b", digit_sel, bi_n, exp_bi);
        end
        wait_blank(ok);
        @(negedge clk);
        total++;
        if (!ok || {digit_sel, bi_n, bcd_a} !== {4'b0111, exp_bi, 4'h0}) begin
            bad++;
            $display("FAIL lz_d3: got sel=%b bi=%b a=%h expected sel=0111 bi=%b a=0", digit_sel, bi_n, bcd_a, exp_bi);
        end
    endtask

    initial begin
        test_reset();
        test_count_scan();
        test_wrap();
        test_hold();
        test_reset_mid_scan();
        test_leading_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
